// File: rtl/debouncer.sv
// Button debouncer: two-flop resynchroniser followed by a stability counter.
// The output changes only after the synchronised input differs from it for DEB_TIME cycles.
module debouncer #(
  parameter int unsigned DEB_TIME = 100
) (
  input  logic aclk,
  input  logic srst,
  input  logic button,
  output logic button_debounced
);

  localparam int unsigned CNT_W = $clog2(DEB_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TIME - 1);

  logic             button_meta;
  logic             button_sync;
  logic [CNT_W-1:0] cnt;

  // Plain two-stage synchroniser, nothing between the stages.
  always_ff @(posedge aclk) begin
    if (srst) begin
      button_meta <= 1'b0;
      button_sync <= 1'b0;
    end else begin
      button_meta <= button;
      button_sync <= button_meta;
    end
  end

  // Any cycle of agreement restarts the window; output flips when the window fills.
  always_ff @(posedge aclk) begin
    if (srst) begin
      cnt              <= '0;
      button_debounced <= 1'b0;
    end else if (button_sync == button_debounced) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt              <= '0;
      button_debounced <= button_sync;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Directed self-checking bench for debouncer at DEB_TIME = 100 with a 4 ns clock.
// Inputs change and outputs are sampled on the falling edge, so latencies are exact.
module tb_debouncer;

  localparam int unsigned DEB_TIME = 100;
  localparam int unsigned LAT      = DEB_TIME + 2;

  logic aclk;
  logic srst;
  logic button;
  logic button_debounced;

  int n_cmp;
  int n_bad;

  debouncer #(.DEB_TIME(DEB_TIME)) dut (
    .aclk             (aclk),
    .srst             (srst),
    .button           (button),
    .button_debounced (button_debounced)
  );

  initial aclk = 1'b0;
  always #2 aclk = ~aclk;

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output must hold from_v for LAT-1 cycles after an input edge, then show to_v.
  task automatic check_latency(input string tag, input logic from_v, input logic to_v);
    for (int i = 1; i < int'(LAT); i++) begin
      tick(1);
      check({tag, "_hold"}, 32'(button_debounced), 32'(from_v));
    end
    tick(1);
    check({tag, "_edge"}, 32'(button_debounced), 32'(to_v));
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    srst   = 1'b1;
    button = 1'b0;

    // Reset
    tick(25);
    check("in_reset_out", 32'(button_debounced), 32'd0);
    check("in_reset_cnt", 32'(dut.cnt), 32'd0);
    srst = 1'b0;
    tick(3);
    check("post_reset_out", 32'(button_debounced), 32'd0);

    // Press: rises exactly 102 cycles after the edge
    button = 1'b1;
    check_latency("press", 1'b0, 1'b1);
    tick(23);
    check("press_steady", 32'(button_debounced), 32'd1);

    // Release: symmetric latency
    button = 1'b0;
    check_latency("release", 1'b1, 1'b0);

    // Glitch of 50 cycles never reaches the output
    tick(5);
    button = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      check("glitch_out", 32'(button_debounced), 32'd0);
    end
    check("glitch_cnt_mid", 32'(dut.cnt), 32'd48);
    button = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      check("glitch_tail_out", 32'(button_debounced), 32'd0);
    end
    check("glitch_cnt_clear", 32'(dut.cnt), 32'd0);

    // Bounce train: toggle every 10 cycles for 300 cycles, then hold high
    for (int t = 0; t < 30; t++) begin
      button = (t % 2 == 0);
      for (int i = 0; i < 10; i++) begin
        tick(1);
        check("bounce_out", 32'(button_debounced), 32'd0);
      end
    end
    button = 1'b1;
    check_latency("bounce_settle", 1'b0, 1'b1);

    button = 1'b0;
    check_latency("bounce_release", 1'b1, 1'b0);

    // Reset at cycle 60 of the counting window
    tick(5);
    button = 1'b1;
    tick(62);
    check("midcount_cnt", 32'(dut.cnt), 32'd60);
    srst = 1'b1;
    tick(1);
    check("midcount_rst_out", 32'(button_debounced), 32'd0);
    check("midcount_rst_cnt", 32'(dut.cnt), 32'd0);
    tick(1);
    srst = 1'b0;
    check_latency("after_rst", 1'b0, 1'b1);

    // Reset while output is high: clears on the next edge, then rises again
    srst = 1'b1;
    tick(1);
    check("rst_high_out", 32'(button_debounced), 32'd0);
    srst = 1'b0;
    check_latency("rst_high_rerise", 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debouncer.md
Name: debouncer

Overview:
- Filters a noisy, asynchronous mechanical button input into a clean, single-clock-domain level.
- The input is first resynchronised into the `aclk` domain.
- The output only changes after the synchronised input has held a new, stable value for `DEB_TIME` consecutive clock cycles.
- Sits between board-level push-buttons and synchronous control logic.

Parameters:
- `DEB_TIME`, default 100: debounce window in `aclk` cycles; legal range ≥ 1.

Ports:
- `aclk`: input, 1 bit. System clock; all logic on the rising edge.
- `srst`: input, 1 bit. Synchronous reset, active-high, sampled on the rising edge of `aclk`.
- `button`: input, 1 bit. Raw button level; asynchronous to `aclk`; may bounce.
- `button_debounced`: output, 1 bit. Debounced, registered button level, synchronous to `aclk`.

Behaviour:
- Reset (`srst` = 1 at a rising edge):
  - synchroniser flops, counter and `button_debounced` all clear to 0;
  - reset takes priority over all other activity, including mid-count.
- Synchroniser:
  - 2-stage flip-flop chain on `button`, reset value 0;
  - `button_sync` is the stage-2 output.
  - No logic is placed between the stages.
- Counter:
  - width `$clog2(DEB_TIME+1)`, unsigned, reset 0.
- Each cycle (not in reset):
  - If `button_sync` == `button_debounced`: counter <= 0 and the output holds.
  - Else, if counter == `DEB_TIME`-1: `button_debounced` <= `button_sync` and counter <= 0.
  - Else: counter <= counter + 1 and the output holds.
- Consequence: the output toggles only after `DEB_TIME` consecutive cycles of `button_sync` differing from the output.
  - Any single cycle of agreement (a bounce back) restarts the window from 0.
- Latency from a clean `button` edge to the `button_debounced` change:
  - 2 (sync) + `DEB_TIME` cycles, ±1 cycle of asynchronous sampling uncertainty;
  - 102 cycles at the default.
- `DEB_TIME` = 1 boundary: the output follows `button_sync` with one cycle of delay; the counter stays 0.
- Counter never exceeds `DEB_TIME`-1, so there is no wrap-around.
- Symmetric behaviour for press (0→1) and release (1→0); no edge preference.
- Output is driven directly from a flop; no combinational path from `button` to the output.
- While `button` is constant and equal to the output, no state changes.
- Asynchronous pulses shorter than `DEB_TIME` cycles (after sync) never reach the output.
- Reset mid-operation:
  - output returns to 0 on the next edge;
  - if `button` is 1 after reset release, the output rises after the full latency again.

Test Plan:
- Reset: hold `srst`=1 for 25 cycles with `button`=0, release, wait 3 cycles -> `button_debounced`=0.
- Press: `DEB_TIME`=100, 4 ns clock; after reset set `button`=1, wait 500 ns -> `button_debounced`=1; the output stays 0 for the first 100 cycles after the press.
- Press then release:
  - after the output reaches 1, set `button`=0;
  - 9 ns later -> still 1;
  - a further 500 ns later -> 0.
- Glitch rejection: with the output at 0, drive `button`=1 for 50 cycles then 0 -> `button_debounced` remains 0 throughout and the counter returns to 0.
- Bounce train: toggle `button` every 10 cycles for 300 cycles, then hold 1 -> the output stays 0 during bouncing, then rises 102±1 cycles after the final stable edge.
- Reset mid-count: press `button`=1, assert `srst` at cycle 60 of the window for 2 cycles, keep `button`=1 -> the output is 0 at reset and rises only ~102 cycles after reset deassertion.
